// File: rtl/aes_ks_pkg.sv
// aes_ks_pkg: shared AES-128 key-schedule constants, FSM state type and the forward S-box.
package aes_ks_pkg;
  localparam int NR = 10;
  localparam logic [8*NR-1:0] RCON_TBL = 80'h01_02_04_08_10_20_40_80_1b_36;
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_e;
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255-int'(b)) +: 8];
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return (i >= 4'd1 && i <= 4'(NR)) ? RCON_TBL[8*(NR-int'(i)) +: 8] : 8'h00;
  endfunction
endpackage

// File: rtl/aes_ks_step.sv
// aes_ks_step: one combinational AES-128 key-expansion step (RotWord, SubWord, XOR chain).
module aes_ks_step
  import aes_ks_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon_in,
  output logic [127:0] next_key
);
  logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
  always_comb begin
    {w0, w1, w2, w3} = prev_key;
    rot = {w3[23:0], w3[31:24]};
    t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon_in, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end
endmodule

// File: rtl/aes_round_key_store.sv
// aes_round_key_store: iterative AES-128 key schedule with an 11-entry round-key store and registered read port.
// Define AES_KS_ZEROIZE_EN to clear the store on reset and hide key material while keys_valid is low.
module aes_round_key_store
  import aes_ks_pkg::*;
#(
  parameter int NR   = 10,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [127:0]    key_in,
  input  logic            key_valid,
  output logic            key_ready,
  output logic            keys_valid,
  input  logic [IDXW-1:0] rd_idx,
  output logic [127:0]    rd_key
);
  ks_state_e state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d, prev_idx, wr_idx;
  logic [127:0] store_q [0:NR];
  logic [127:0] rd_key_q, rd_key_d, next_key, wr_data;
  logic wr_en;
  assign prev_idx = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
  aes_ks_step u_step (
    .prev_key (store_q[prev_idx]),
    .rcon_in  (rcon(cnt_q)),
    .next_key (next_key)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_en = 1'b0;
    wr_idx = cnt_q;
    wr_data = next_key;
    key_ready = state_q != EXPAND;
    keys_valid = state_q == DONE;
    if (key_valid && key_ready) begin
      state_d = EXPAND;
      cnt_d = IDXW'(1);
      wr_en = 1'b1;
      wr_idx = '0;
      wr_data = key_in;
    end else if (state_q == EXPAND) begin
      wr_en = 1'b1;
      state_d = (cnt_q == IDXW'(NR)) ? DONE : EXPAND;
      cnt_d = (cnt_q == IDXW'(NR)) ? cnt_q : cnt_q + 1'b1;
    end
    rd_key_d = (rd_idx <= IDXW'(NR)) ? store_q[rd_idx] : '0;
`ifdef AES_KS_ZEROIZE_EN
    rd_key_d = keys_valid ? rd_key_d : '0;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_key_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_key_q <= rd_key_d;
    end
  end
`ifdef AES_KS_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) store_q[i] <= '0;
    end else if (wr_en) begin
      store_q[wr_idx] <= wr_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) store_q[wr_idx] <= wr_data;
  end
`endif
  assign rd_key = rd_key_q;
endmodule
